// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the byte-lane helpers for store enables and load formatting.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    function automatic logic [31:0] fmt_load(input logic [2:0]  funct3,
                                             input logic [1:0]  offset,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    fmt_load = {{24{b[7]}}, b};
            F3_H:    fmt_load = {{16{h[15]}}, h};
            F3_W:    fmt_load = word;
            F3_BU:   fmt_load = {24'h0, b};
            F3_HU:   fmt_load = {16'h0, h};
            default: fmt_load = 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] offset);
        case (funct3)
            F3_B:    store_be = 4'b0001 << offset;
            F3_H:    store_be = offset[1] ? 4'b1100 : 4'b0011;
            F3_W:    store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    // Replicate the narrow store data across all lanes; the enables pick the lane.
    function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
        case (funct3)
            F3_B:    store_data = {4{wdata[7:0]}};
            F3_H:    store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_dmem_be.sv
// Word-organised data memory with per-byte write enables, synchronous write
// and combinational read. Contents are deliberately not reset.
module dmem_be #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: validates load/store requests, sequences wait states,
// stalls the pipeline and formats load data from the byte-enabled memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        ExceptM,
    output lsu_state_t  dbg_state
);

    localparam int         ADDR_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] W_LAST  = 4'(WAIT_STATES);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);

    // Handshake: a request (MemReadM or MemWriteM) is presented by EX/MEM and
    // must stay stable while StallM is high; it completes in the first cycle
    // with StallM low, which is when load data is valid and a store commits.

    lsu_state_t state;
    logic [3:0] cnt;

    logic [1:0]  offset;
    logic        req, both, f3_bad, misal, reject, ok, done, we;
    logic [31:0] mem_rdata;
    logic        unused_addr;

    assign offset      = ALUResultM[1:0];
    assign unused_addr = ^ALUResultM[31:ADDR_W+2];

    always_comb begin
        req    = MemReadM | MemWriteM;
        both   = MemReadM & MemWriteM;
        f3_bad = 1'b0;
        if (MemReadM) begin
            f3_bad = !(Funct3M inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else if (MemWriteM) begin
            f3_bad = !(Funct3M inside {F3_B, F3_H, F3_W});
        end
        misal  = ((Funct3M[1:0] == 2'b01) && offset[0]) ||
                 ((Funct3M[1:0] == 2'b10) && (offset != 2'b00));
        reject = req & (both | f3_bad | misal);
        ok     = req & ~reject;
        done   = ok & (NO_WAIT ? (state == IDLE)
                               : ((state == WAIT) && (cnt == W_LAST)));
    end

    // Everything is gated by rst so a held request cannot stall or write
    // while the unit is in reset.
    assign we        = rst & done & MemWriteM;
    assign StallM    = rst & ok & ~done;
    assign ExceptM   = rst & reject & (state == IDLE);
    assign ReadDataM = (rst & done & MemReadM) ? fmt_load(Funct3M, offset, mem_rdata)
                                               : 32'h0;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ok && !NO_WAIT) begin
                        state <= WAIT;
                        cnt   <= 4'd1;
                    end
                end
                WAIT: begin
                    if (cnt >= W_LAST) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    dmem_be #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_dmem (
        .clk  (clk),
        .we   (we),
        .be   (store_be(Funct3M, offset)),
        .addr (ALUResultM[ADDR_W+1:2]),
        .wdata(store_data(Funct3M, WriteDataM)),
        .rdata(mem_rdata)
    );

endmodule
